serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; the legal range is 1 to 32.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have input start, 1 bit: request to begin a subtraction, sampled only in IDLE.
REQ-005 The block SHALL have input A, WIDTH bits: the minuend, captured on the accepting edge.
REQ-006 The block SHALL have input B, WIDTH bits: the subtrahend, captured on the accepting edge.
REQ-007 The block SHALL have input Bin, 1 bit: the borrow-in, captured on the accepting edge.
REQ-008 The block SHALL have output D, WIDTH bits: the registered difference A-B-Bin modulo 2^WIDTH.
REQ-009 The block SHALL have output Bout, 1 bit: the registered final borrow-out; 1 means A < B+Bin, unsigned.
REQ-010 The block SHALL have output busy, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have output done, 1 bit: a single-cycle pulse marking D and Bout valid.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at an edge (the accept edge), the block SHALL load A and B into shift registers, load Bin into the borrow flop, clear the bit counter, set busy=1 and go to SHIFT.
REQ-014 In SHIFT, each edge SHALL process one bit, LSB first, with a=A_sr[0] and b=B_sr[0].
REQ-015 The difference bit SHALL be a^b^br.
REQ-016 The next borrow SHALL be (~a&b)|(~(a^b)&br).
REQ-017 Each SHIFT edge SHALL shift the difference bit into D_sr from the MSB side and shift A_sr and B_sr right.
REQ-018 After the WIDTH-th SHIFT edge, the block SHALL copy D_sr to D and the borrow to Bout, set done=1, clear busy and go to DONE.
REQ-019 done SHALL rise exactly WIDTH edges after the accept edge, and the block SHALL spend exactly WIDTH SHIFT edges, including for WIDTH=1.
REQ-020 DONE SHALL last exactly one cycle; the block SHALL then clear done and return to IDLE unconditionally.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored, with no queuing; the earliest next accept is the first edge in IDLE.
REQ-022 D and Bout SHALL hold their last result until the next DONE, and SHALL NOT change during SHIFT.
REQ-023 A, B and Bin SHALL be don't-care except at the accept edge; changes during SHIFT SHALL have no effect.
REQ-024 Wrap-around: a result below 0 SHALL wrap modulo 2^WIDTH with Bout=1.

Reset
REQ-025 When rst_n=0, the block SHALL immediately, without waiting for clk, force state to IDLE and D, Bout, busy and done to 0, and clear all shift registers, the borrow flop and the counter.
REQ-026 A reset asserted mid-SHIFT SHALL abort the operation with no done pulse, and the result outputs SHALL read 0.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-028 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add output V, 1 bit, giving two's-complement overflow: (A[MSB]^B[MSB]) & (D[MSB]^A[MSB]) using the captured operands, registered with D, reset to 0 and held like D.
REQ-029 Without SERIAL_SUB_OVF_EN, port V and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Basic subtraction: WIDTH=8, A=0x05, B=0x03, Bin=0, start one cycle -> busy for 8 cycles, done pulse at accept edge+8, D=0x02, Bout=0.
REQ-031 Wrap-around: A=0x03, B=0x05, Bin=0 -> D=0xFE, Bout=1.
REQ-032 Borrow-in and zero operands: A=0x00, B=0x00, Bin=1 -> D=0xFF, Bout=1.
REQ-033 Start while busy: accept A=0x10, B=0x01; 3 cycles later start=1 with A=0xFF -> single done, D=0x0F, Bout=0; start is accepted again only after return to IDLE.
REQ-034 Reset mid-operation: drop rst_n at SHIFT bit 4 between edges -> outputs read 0 immediately, no done; a following A=0x09, B=0x09 -> D=0x00, Bout=0.
REQ-035 Overflow (with SERIAL_SUB_OVF_EN): A=0x80, B=0x01 -> D=0x7F, V=1, Bout=0.
REQ-036 Minimum width: with WIDTH=1, A=0, B=1 -> D=1, Bout=1, done at accept edge+1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B-Bin, LSB first, one bit per clock, result after WIDTH shift edges.
// Optional SERIAL_SUB_OVF_EN adds output V (two's-complement overflow of the captured operands).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_next;
  logic [CW-1:0]    cnt;
  logic             br, dbit, br_next, last;
  always_comb begin
    dbit    = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    d_next  = (d_sr >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
    last    = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= A;
          b_sr  <= B;
          br    <= Bin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          d_sr <= d_next;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            D     <= d_next;
            Bout  <= br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  // operand sign bits are shifted out of a_sr/b_sr, so keep them separately
  logic am, bm;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am <= 1'b0;
      bm <= 1'b0;
      V  <= 1'b0;
    end else if (state == IDLE && start) begin
      am <= A[WIDTH-1];
      bm <= B[WIDTH-1];
    end else if (state == SHIFT && last) begin
      V <= (am ^ bm) & (d_next[WIDTH-1] ^ am);
    end
  end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table for WIDTH=8 plus hand sequences and a WIDTH=1 instance.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, Bin = 1'b0;
  logic [7:0] A = '0, B = '0, D;
  logic Bout, busy, done;
  logic s1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic d1, bout1, busy1, done1;
`ifdef SERIAL_SUB_OVF_EN
  logic V, v1;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .busy(busy), .done(done)
`ifdef SERIAL_SUB_OVF_EN
    , .V(V)
`endif
  );
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1), .Bin(bin1),
    .D(d1), .Bout(bout1), .busy(busy1), .done(done1)
`ifdef SERIAL_SUB_OVF_EN
    , .V(v1)
`endif
  );
  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bout, v;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bin, output int lat, output logic held);
    logic [7:0] prev;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
    prev = D;
    held = 1'b1;
    chk("busy_after_accept", busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done && D !== prev) held = 1'b0;
    end
  endtask
  initial begin
    int lat;
    logic held;
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[8] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};
    #12;
    chk("rst_D", D, 0);
    chk("rst_Bout", Bout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, held);
      chk($sformatf("lat[%0d]", i), lat, 8);
      chk($sformatf("hold[%0d]", i), held, 1);
      chk($sformatf("D[%0d]", i), D, vecs[i].d);
      chk($sformatf("Bout[%0d]", i), Bout, vecs[i].bout);
      chk($sformatf("busy_done[%0d]", i), busy, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("V[%0d]", i), V, vecs[i].v);
`endif
      @(posedge clk); #1;
      chk($sformatf("done_pulse[%0d]", i), done, 0);
    end
    // start held high while busy must not queue a second operation
    @(negedge clk);
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    A = 8'hFF; start = 1'b1;
    lat = 3;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_lat", lat, 8);
    chk("busy_start_D", D, 8'h0F);
    chk("busy_start_Bout", Bout, 0);
    @(posedge clk); #1;
    chk("no_accept_in_done", busy, 0);
    chk("single_done", done, 0);
    @(posedge clk); #1;
    chk("accept_in_idle", busy, 1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("second_lat", lat, 8);
    chk("second_D", D, 8'hFE);
    @(posedge clk); #1;
    // asynchronous reset in the middle of a shift
    @(negedge clk);
    A = 8'h33; B = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_D", D, 0);
    chk("mid_rst_Bout", Bout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    op(8'h09, 8'h09, 1'b0, lat, held);
    chk("after_rst_lat", lat, 8);
    chk("after_rst_D", D, 8'h00);
    chk("after_rst_Bout", Bout, 0);
    @(posedge clk); #1;
    // WIDTH=1 instance
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_no_early_done", done1, 0);
    @(posedge clk); #1;
    chk("w1_done", done1, 1);
    chk("w1_D", d1, 1);
    chk("w1_Bout", bout1, 1);
    chk("w1_busy_clr", busy1, 0);
    @(posedge clk); #1;
    chk("w1_done_clr", done1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
